bit_destuffer: RTL and testbench

Upstream neighbour of the frame maker. It watches sampled CAN bits and predicts whether the next bit on the bus is a stuff bit. The prediction is driven as isStuff, which the frame controller, size counter and frame storage use to skip that bit. The block also:
- detects stuff-rule violations;
- handles CAN FD fixed stuffing in the stuff-count/CRC field;
- captures the FD stuff count as Gray code plus parity.

---
 rtl/bit_destuffer_pkg.sv | 19 +
 rtl/bit_destuffer_gray.sv | 14 +
 rtl/bit_destuffer.sv | 144 ++++++++++++++
 tb/tb_bit_destuffer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bit_destuffer_pkg.sv
// Shared types and helpers for the CAN bit destuffer: state encoding,
// counter widths, default stuffing parameters and binary-to-Gray conversion.
package bit_destuffer_pkg;

  localparam int unsigned CNT_W            = 3;
  localparam int unsigned DEF_RUN_LEN      = 5;
  localparam int unsigned DEF_FIXED_PERIOD = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DYNAMIC = 2'd1,
    FIXED   = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] bin2gray(input logic [CNT_W-1:0] i_bin);
    return i_bin ^ (i_bin >> 1);
  endfunction

endpackage

// File: rtl/bit_destuffer_gray.sv
// Combinational conversion of the dynamic stuff count into Gray code plus
// its parity, as carried in the CAN FD stuff-count field.
module bit_destuffer_gray
  import bit_destuffer_pkg::*;
(
  input  logic [CNT_W-1:0] i_bin,
  output logic [CNT_W-1:0] o_gray,
  output logic             o_parity
);

  assign o_gray   = bin2gray(i_bin);
  assign o_parity = ^o_gray;

endmodule

// File: rtl/bit_destuffer.sv
// Predicts stuff bits on the sampled CAN bit stream, checks the stuff rule,
// and switches to FD fixed stuffing in the stuff-count/CRC region.
module bit_destuffer
  import bit_destuffer_pkg::*;
#(
  parameter int unsigned RUN_LEN      = DEF_RUN_LEN,
  parameter int unsigned FIXED_PERIOD = DEF_FIXED_PERIOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             samplePoint,
  input  logic             canRX,
  input  logic             isStart,
  input  logic             BS_onoff,
  input  logic             CRCtime,
  input  logic             EDL,
  input  logic             isError,
  output logic             isStuff,
  output logic             stuffError,
  output logic [CNT_W-1:0] stuffCountGray,
  output logic             stuffParity
);

  state_e           r_state;
  logic [CNT_W-1:0] r_run_cnt;
  logic [CNT_W-1:0] r_fix_cnt;
  logic [CNT_W-1:0] r_dyn_cnt;
  logic             r_last_bit;

  logic             w_same;
  logic [CNT_W-1:0] w_run_sat;
  logic [CNT_W-1:0] w_run_next;
  logic [CNT_W-1:0] w_fix_next;
  logic             w_fd_entry;
  logic [CNT_W-1:0] w_gray;
  logic             w_parity;

  assign w_same     = (canRX == r_last_bit);
  assign w_run_sat  = (r_run_cnt == CNT_W'(RUN_LEN)) ? r_run_cnt : r_run_cnt + CNT_W'(1);
  assign w_run_next = w_same ? w_run_sat : CNT_W'(1);
  assign w_fix_next = r_fix_cnt + CNT_W'(1);
  assign w_fd_entry = EDL & CRCtime;

  bit_destuffer_gray u_gray (
    .i_bin    (r_dyn_cnt),
    .o_gray   (w_gray),
    .o_parity (w_parity)
  );

  // Per-sample sequencing; everything holds between sample points.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_run_cnt      <= '0;
      r_fix_cnt      <= '0;
      r_dyn_cnt      <= '0;
      r_last_bit     <= 1'b1;
      isStuff        <= 1'b0;
      stuffError     <= 1'b0;
      stuffCountGray <= '0;
      stuffParity    <= 1'b0;
    end else begin
      stuffError <= 1'b0;
      if (samplePoint) begin
        if (isError) begin
          r_state <= IDLE;
          isStuff <= 1'b0;
        end else if (isStart) begin
          r_state        <= DYNAMIC;
          r_last_bit     <= canRX;
          r_run_cnt      <= CNT_W'(1);
          r_dyn_cnt      <= '0;
          r_fix_cnt      <= '0;
          isStuff        <= 1'b0;
          stuffCountGray <= '0;
          stuffParity    <= 1'b0;
        end else if (!BS_onoff) begin
          r_state <= IDLE;
          isStuff <= 1'b0;
        end else begin
          case (r_state)
            IDLE: begin
              isStuff <= 1'b0;
            end

            DYNAMIC: begin
              if (w_fd_entry) begin
                // Leading fixed stuff bit; absorbs any dynamic stuff predicted here.
                stuffCountGray <= w_gray;
                stuffParity    <= w_parity;
                isStuff        <= 1'b0;
                if (w_same) begin
                  stuffError <= 1'b1;
                  r_state    <= IDLE;
                end else begin
                  r_state    <= FIXED;
                  r_fix_cnt  <= '0;
                  r_last_bit <= canRX;
                end
              end else if (isStuff) begin
                isStuff <= 1'b0;
                if (w_same) begin
                  stuffError <= 1'b1;
                  r_state    <= IDLE;
                end else begin
                  // The stuff bit opens the next run.
                  r_dyn_cnt  <= r_dyn_cnt + CNT_W'(1);
                  r_last_bit <= canRX;
                  r_run_cnt  <= CNT_W'(1);
                end
              end else begin
                r_run_cnt  <= w_run_next;
                r_last_bit <= canRX;
                isStuff    <= (w_run_next == CNT_W'(RUN_LEN));
              end
            end

            FIXED: begin
              if (isStuff) begin
                isStuff    <= 1'b0;
                r_fix_cnt  <= '0;
                r_last_bit <= canRX;
                if (w_same) begin
                  stuffError <= 1'b1;
                  r_state    <= IDLE;
                end
              end else begin
                r_fix_cnt  <= w_fix_next;
                r_last_bit <= canRX;
                isStuff    <= (w_fix_next == CNT_W'(FIXED_PERIOD));
              end
            end

            default: begin
              r_state <= IDLE;
              isStuff <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_destuffer.sv
// Directed bench for bit_destuffer: dynamic stuffing, violations, FD fixed
// stuffing with Gray stuff count, wrap, region exit, abort and reset.
module tb_bit_destuffer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       samplePoint = 1'b0;
  logic       canRX = 1'b1;
  logic       isStart = 1'b0;
  logic       BS_onoff = 1'b0;
  logic       CRCtime = 1'b0;
  logic       EDL = 1'b0;
  logic       isError = 1'b0;
  logic       isStuff;
  logic       stuffError;
  logic [2:0] stuffCountGray;
  logic       stuffParity;

  int   n_cmp = 0;
  int   n_err = 0;
  logic edl_mode = 1'b0;
  logic tb_last = 1'b0;

  bit_destuffer dut (
    .clk            (clk),
    .rst            (rst),
    .samplePoint    (samplePoint),
    .canRX          (canRX),
    .isStart        (isStart),
    .BS_onoff       (BS_onoff),
    .CRCtime        (CRCtime),
    .EDL            (EDL),
    .isError        (isError),
    .isStuff        (isStuff),
    .stuffError     (stuffError),
    .stuffCountGray (stuffCountGray),
    .stuffParity    (stuffParity)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One sampled bit; outputs are settled 1 time unit after the edge.
  task automatic drive_bit(input logic rx, input logic start, input logic bs,
                           input logic crc, input logic err);
    @(negedge clk);
    canRX = rx; isStart = start; BS_onoff = bs; CRCtime = crc;
    EDL = edl_mode; isError = err; samplePoint = 1'b1;
    @(posedge clk);
    #1;
    samplePoint = 1'b0; isStart = 1'b0; isError = 1'b0;
  endtask

  task automatic sof();
    drive_bit(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tb_last = 1'b0;
  endtask

  task automatic nb(input logic rx);
    drive_bit(rx, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic cb(input logic rx);
    drive_bit(rx, 1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  // n correct dynamic stuff events starting from a fresh run of length 1
  task automatic run_stuffs(input int n);
    for (int k = 0; k < n; k++) begin
      repeat (4) nb(tb_last);
      nb(~tb_last);
      tb_last = ~tb_last;
    end
  endtask

  initial begin
    // Reset state
    #1;
    check_val("rst_stuff", 8'(isStuff), 8'd0);
    check_val("rst_err", 8'(stuffError), 8'd0);
    check_val("rst_gray", 8'(stuffCountGray), 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1. async reset mid-frame with a stuff bit pending
    sof();
    repeat (4) nb(1'b0);
    check_val("pre_rst_stuff", 8'(isStuff), 8'd1);
    rst = 1'b1;
    #1;
    check_val("async_rst_stuff", 8'(isStuff), 8'd0);
    check_val("async_rst_err", 8'(stuffError), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) nb(1'b0);
    check_val("post_rst_idle", 8'(isStuff), 8'd0);

    // 2. classic dynamic stuffing
    sof();
    repeat (3) nb(1'b0);
    check_val("dyn_run4", 8'(isStuff), 8'd0);
    nb(1'b0);
    check_val("dyn_run5", 8'(isStuff), 8'd1);
    nb(1'b1);
    check_val("dyn_stuff_clr", 8'(isStuff), 8'd0);
    check_val("dyn_stuff_ok", 8'(stuffError), 8'd0);
    repeat (3) nb(1'b1);
    check_val("dyn_run4b", 8'(isStuff), 8'd0);
    nb(1'b1);
    check_val("dyn_stuff_in_run", 8'(isStuff), 8'd1);

    // 3. stuff violation
    sof();
    repeat (4) nb(1'b0);
    nb(1'b0);
    check_val("viol_pulse", 8'(stuffError), 8'd1);
    check_val("viol_stuff", 8'(isStuff), 8'd0);
    @(posedge clk);
    #1;
    check_val("viol_one_clk", 8'(stuffError), 8'd0);
    repeat (6) nb(1'b0);
    check_val("viol_idle_stuff", 8'(isStuff), 8'd0);
    check_val("viol_idle_err", 8'(stuffError), 8'd0);

    // 4. FD fixed stuffing after three dynamic stuffs
    edl_mode = 1'b1;
    sof();
    run_stuffs(3);
    check_val("fd_last_is_1", 8'(tb_last), 8'd1);
    cb(1'b0);
    check_val("fd_gray3", 8'(stuffCountGray), 8'h2);
    check_val("fd_par3", 8'(stuffParity), 8'd1);
    check_val("fd_entry_err", 8'(stuffError), 8'd0);
    check_val("fd_entry_stuff", 8'(isStuff), 8'd0);
    cb(1'b1); cb(1'b0); cb(1'b1);
    check_val("fd_data3", 8'(isStuff), 8'd0);
    cb(1'b0);
    check_val("fd_data4", 8'(isStuff), 8'd1);
    cb(1'b0);
    check_val("fd_stuff_viol", 8'(stuffError), 8'd1);

    // 5. dynCnt wrap (9 stuffs) and a correct fixed stuff bit
    sof();
    check_val("sof_clr_gray", 8'(stuffCountGray), 8'd0);
    run_stuffs(9);
    cb(1'b0);
    check_val("wrap_gray", 8'(stuffCountGray), 8'h1);
    check_val("wrap_par", 8'(stuffParity), 8'd1);
    check_val("wrap_entry_err", 8'(stuffError), 8'd0);
    repeat (4) cb(1'b1);
    check_val("wrap_fix_due", 8'(isStuff), 8'd1);
    cb(1'b0);
    check_val("wrap_fix_ok", 8'(stuffError), 8'd0);
    check_val("wrap_fix_clr", 8'(isStuff), 8'd0);
    check_val("wrap_gray_hold", 8'(stuffCountGray), 8'h1);

    // Entry absorbs a pending dynamic stuff: count stays 1, not 2
    sof();
    run_stuffs(1);
    repeat (4) nb(tb_last);
    check_val("absorb_pending", 8'(isStuff), 8'd1);
    cb(~tb_last);
    check_val("absorb_gray", 8'(stuffCountGray), 8'h1);
    check_val("absorb_err", 8'(stuffError), 8'd0);
    check_val("absorb_stuff", 8'(isStuff), 8'd0);

    // Classic frame ignores CRCtime
    edl_mode = 1'b0;
    sof();
    repeat (4) cb(1'b0);
    check_val("classic_crc_dyn", 8'(isStuff), 8'd1);

    // 6. region exit and abort
    sof();
    repeat (6) drive_bit(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("bsoff_stuff", 8'(isStuff), 8'd0);
    check_val("bsoff_err", 8'(stuffError), 8'd0);
    sof();
    repeat (4) nb(1'b0);
    check_val("abort_pre", 8'(isStuff), 8'd1);
    drive_bit(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("abort_stuff", 8'(isStuff), 8'd0);
    check_val("abort_err", 8'(stuffError), 8'd0);
    repeat (6) nb(1'b0);
    check_val("abort_idle", 8'(isStuff), 8'd0);
    check_val("abort_idle_err", 8'(stuffError), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
